// File: rtl/fwd_scoreboard.sv
// EX-stage operand forwarding scoreboard: tracks in-flight register writes over
// DEPTH post-EX stages, drives per-source forwarding selects and load-use stall.
module fwd_scoreboard #(
    parameter int NUM_SRC    = 2,
    parameter int DEPTH      = 2,
    parameter int REG_AW     = 5,
    parameter int LOAD_STAGE = 1,
    parameter int CNT_W      = 16,
    localparam int SEL_W     = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      hold,
    input  logic                      flush,
    input  logic                      ex_valid,
    input  logic                      ex_we,
    input  logic [REG_AW-1:0]         ex_rd,
    input  logic                      ex_is_load,
    input  logic [NUM_SRC*REG_AW-1:0] src_addr,
    input  logic [NUM_SRC-1:0]        src_is_reg,
    output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
    output logic                      stall,
    output logic [CNT_W-1:0]          stall_cnt
);

    localparam int unsigned LS = LOAD_STAGE;

    logic [DEPTH-1:0]  valid_q;
    logic [DEPTH-1:0]  we_q;
    logic [DEPTH-1:0]  load_q;
    logic [REG_AW-1:0] rd_q [DEPTH];
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              entry0_valid_d;

    logic [DEPTH-1:0]   live;
    logic [NUM_SRC-1:0] found;
    logic               stall_src;

    // An entry can only ever forward if it is a real, non-r0 register write.
    always_comb begin
        live = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            live[k] = valid_q[k] & we_q[k] & (rd_q[k] != '0);
        end
    end

    // Ascending scan with a found flag: the lowest (youngest) matching entry wins.
    always_comb begin
        fwd_sel   = '0;
        found     = '0;
        stall_src = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                if (!found[i] && live[k] && src_is_reg[i] &&
                    (rd_q[k] == src_addr[i*REG_AW +: REG_AW])) begin
                    found[i] = 1'b1;
                    fwd_sel[i*SEL_W +: SEL_W] = SEL_W'(k + 1);
                    if (load_q[k] && (k < LS)) begin
                        stall_src = 1'b1;
                    end
                end
            end
        end
    end

    assign stall          = ex_valid & ~flush & stall_src;
    assign entry0_valid_d = ex_valid & ~stall & ~flush;
    assign cnt_d          = (stall && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;
    assign stall_cnt      = cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            we_q    <= '0;
            load_q  <= '0;
            cnt_q   <= '0;
            for (int unsigned k = 0; k < DEPTH; k++) begin
                rd_q[k] <= '0;
            end
        end else if (!hold) begin
            for (int unsigned k = 1; k < DEPTH; k++) begin
                valid_q[k] <= valid_q[k-1];
                we_q[k]    <= we_q[k-1];
                load_q[k]  <= load_q[k-1];
                rd_q[k]    <= rd_q[k-1];
            end
            valid_q[0] <= entry0_valid_d;
            we_q[0]    <= ex_we;
            load_q[0]  <= ex_is_load;
            rd_q[0]    <= ex_rd;
            cnt_q      <= cnt_d;
        end
    end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench for fwd_scoreboard: history-list model checked every cycle,
// plus literal expectations at key points of each scenario.
module tb_fwd_scoreboard;

    localparam int DEPTH = 2;
    localparam int LOAD_STAGE = 1;

    logic       clk;
    logic       rst;
    logic       hold;
    logic       flush;
    logic       ex_valid;
    logic       ex_we;
    logic [4:0] ex_rd;
    logic       ex_is_load;
    logic [9:0] src_addr;
    logic [1:0] src_is_reg;
    logic [3:0] fwd_sel;
    logic       stall;
    logic [3:0] stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    fwd_scoreboard #(
        .NUM_SRC(2), .DEPTH(DEPTH), .REG_AW(5), .LOAD_STAGE(LOAD_STAGE), .CNT_W(4)
    ) dut (
        .clk(clk), .rst(rst), .hold(hold), .flush(flush),
        .ex_valid(ex_valid), .ex_we(ex_we), .ex_rd(ex_rd), .ex_is_load(ex_is_load),
        .src_addr(src_addr), .src_is_reg(src_is_reg),
        .fwd_sel(fwd_sel), .stall(stall), .stall_cnt(stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // History of instructions that left EX; hist[0] is the most recent.
    typedef struct packed {
        logic       v;
        logic       we;
        logic [4:0] rd;
        logic       ld;
    } rec_t;

    rec_t       hist [DEPTH];
    logic [3:0] mcnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Search the history for the newest write to each source; a late load stalls.
    function automatic void model_eval(output logic [3:0] sel, output logic st);
        logic [4:0] a;
        logic       need;
        sel  = '0;
        need = 1'b0;
        for (int i = 0; i < 2; i++) begin
            a = (i == 0) ? src_addr[4:0] : src_addr[9:5];
            for (int k = 0; k < DEPTH; k++) begin
                if (src_is_reg[i] && hist[k].v && hist[k].we && hist[k].rd != 5'd0 && hist[k].rd == a) begin
                    if (i == 0) sel[1:0] = 2'(k + 1);
                    else        sel[3:2] = 2'(k + 1);
                    if (hist[k].ld && k < LOAD_STAGE) need = 1'b1;
                    break;
                end
            end
        end
        st = ex_valid && !flush && need;
    endfunction

    always @(posedge clk) begin
        logic [3:0] s;
        logic       st;
        model_eval(s, st);
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) hist[k] = '0;
            mcnt = '0;
        end else if (!hold) begin
            for (int k = DEPTH - 1; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = '{ex_valid && !st && !flush, ex_we, ex_rd, ex_is_load};
            if (st && mcnt != 4'hF) mcnt = mcnt + 4'd1;
        end
    end

    always @(negedge clk) begin
        logic [3:0] s;
        logic       st;
        if (chk_en) begin
            model_eval(s, st);
            chk("model_fwd_sel", 32'(fwd_sel), 32'(s));
            chk("model_stall", 32'(stall), 32'(st));
            chk("model_stall_cnt", 32'(stall_cnt), 32'(mcnt));
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic we, input logic [4:0] rd, input logic ld,
                         input logic [4:0] s0, input logic [4:0] s1, input logic [1:0] isr,
                         input logic hl, input logic fl, input logic rs);
        ex_valid   = v;
        ex_we      = we;
        ex_rd      = rd;
        ex_is_load = ld;
        src_addr   = {s1, s0};
        src_is_reg = isr;
        hold       = hl;
        flush      = fl;
        rst        = rs;
        #1;
    endtask

    task automatic lit(input string nm, input logic [3:0] sel, input logic st, input logic [3:0] cnt);
        chk({nm, "_sel"}, 32'(fwd_sel), 32'(sel));
        chk({nm, "_stall"}, 32'(stall), 32'(st));
        chk({nm, "_cnt"}, 32'(stall_cnt), 32'(cnt));
    endtask

    task automatic nop;
        drive(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
        tick();
    endtask

    task automatic lw8;
        drive(1, 1, 5'd8, 1, 0, 0, 2'b00, 0, 0, 0);
        tick();
    endtask

    initial begin
        for (int k = 0; k < DEPTH; k++) hist[k] = '0;
        mcnt = '0;
        drive(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1);
        tick();
        tick();
        drive(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
        chk_en = 1'b1;
        lit("reset", 4'b0000, 0, 4'd0);
        tick();

        // Reset while a load-use stall is pending
        lw8();
        drive(1, 1, 5'd9, 0, 5'd8, 5'd0, 2'b11, 0, 0, 1);
        lit("t1_pre_rst", 4'b0001, 1, 4'd0);
        tick();
        drive(1, 1, 5'd9, 0, 5'd8, 5'd0, 2'b11, 0, 0, 0);
        lit("t1_post_rst", 4'b0000, 0, 4'd0);
        tick();
        nop(); nop();

        // ALU chain on rs, then on rt
        drive(1, 1, 5'd5, 0, 0, 0, 2'b00, 0, 0, 0); tick();
        drive(1, 0, 5'd0, 0, 5'd5, 5'd0, 2'b01, 0, 0, 0);
        lit("t2_rs_e0", 4'b0001, 0, 4'd0);
        tick();
        drive(1, 0, 5'd0, 0, 5'd5, 5'd0, 2'b01, 0, 0, 0);
        lit("t2_rs_e1", 4'b0010, 0, 4'd0);
        tick();
        nop(); nop();
        drive(1, 1, 5'd5, 0, 0, 0, 2'b00, 0, 0, 0); tick();
        drive(1, 0, 5'd0, 0, 5'd0, 5'd5, 2'b10, 0, 0, 0);
        lit("t2_rt_e0", 4'b0100, 0, 4'd0);
        tick();
        nop(); nop();

        // Load-use: one stall, then forward from entry 1
        lw8();
        drive(1, 1, 5'd10, 0, 5'd8, 5'd0, 2'b01, 0, 0, 0);
        lit("t3_stall", 4'b0001, 1, 4'd0);
        tick();
        drive(1, 1, 5'd10, 0, 5'd8, 5'd0, 2'b01, 0, 0, 0);
        lit("t3_fwd", 4'b0010, 0, 4'd1);
        tick();
        nop(); nop();

        // Youngest wins; immediate operand never forwards
        drive(1, 1, 5'd3, 0, 0, 0, 2'b00, 0, 0, 0); tick();
        drive(1, 1, 5'd3, 0, 0, 0, 2'b00, 0, 0, 0); tick();
        drive(1, 0, 5'd0, 0, 5'd3, 5'd3, 2'b01, 0, 0, 0);
        lit("t4_young_mask", 4'b0001, 0, 4'd1);
        tick();
        nop(); nop();

        // Register 0 is never forwarded
        drive(1, 1, 5'd0, 0, 0, 0, 2'b00, 0, 0, 0); tick();
        drive(1, 0, 5'd0, 0, 5'd0, 5'd0, 2'b11, 0, 0, 0);
        lit("t5_r0_e0", 4'b0000, 0, 4'd1);
        tick();
        drive(1, 0, 5'd0, 0, 5'd0, 5'd0, 2'b11, 0, 0, 0);
        lit("t5_r0_e1", 4'b0000, 0, 4'd1);
        tick();
        nop(); nop();

        // Hold freezes a pending load-use stall
        lw8();
        for (int c = 0; c < 3; c++) begin
            drive(1, 1, 5'd10, 0, 5'd8, 5'd0, 2'b01, 1, 0, 0);
            lit("t6_hold", 4'b0001, 1, 4'd1);
            tick();
        end
        drive(1, 1, 5'd10, 0, 5'd8, 5'd0, 2'b01, 0, 0, 0);
        lit("t6_release", 4'b0001, 1, 4'd1);
        tick();
        drive(1, 1, 5'd10, 0, 5'd8, 5'd0, 2'b01, 0, 0, 0);
        lit("t6_after", 4'b0010, 0, 4'd2);
        tick();
        nop(); nop();

        // Flush with a hazard present: no stall, bubble enters
        lw8();
        drive(1, 1, 5'd10, 0, 5'd8, 5'd0, 2'b01, 0, 1, 0);
        lit("t6_flush", 4'b0001, 0, 4'd2);
        tick();
        drive(1, 0, 5'd0, 0, 5'd8, 5'd10, 2'b11, 0, 0, 0);
        lit("t6_bubble", 4'b0010, 0, 4'd2);
        tick();
        nop(); nop();

        // Drive the counter into saturation
        for (int c = 0; c < 16; c++) begin
            lw8();
            drive(1, 0, 5'd0, 0, 5'd8, 5'd0, 2'b01, 0, 0, 0);
            tick();
        end
        lw8();
        drive(1, 0, 5'd0, 0, 5'd8, 5'd0, 2'b01, 0, 0, 0);
        lit("t6_sat_stall", 4'b0001, 1, 4'hF);
        tick();
        drive(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
        lit("t6_sat_hold", 4'b0000, 0, 4'hF);
        tick();

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
